// File: rtl/step_phase_decoder.sv
// Stepper coil pattern decoder: synchronizes and debounces the 4-bit coil drive,
// then tracks phase transitions into a signed step position with error flags.
module step_phase_decoder #(
    parameter int unsigned POS_WIDTH     = 16,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter int unsigned IDLE_CYCLES   = 1000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  signal_in,
    input  logic                        zero_pos,
    input  logic                        clr_err,
    output logic signed [POS_WIDTH-1:0] position,
    output logic                        dir_out,
    output logic                        step_pulse,
    output logic                        moving,
    output logic                        ref_valid,
    output logic                        err_skip,
    output logic                        err_illegal
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDL_W = 24;
    localparam logic [CNT_W-1:0] FILT_MAX  = CNT_W'(FILTER_CYCLES);
    localparam logic [IDL_W-1:0] IDLE_LOAD = IDL_W'(IDLE_CYCLES);

    logic [3:0]           sync1_q, sync2_q;
    logic [3:0]           cand_q, cand_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           acc_q, acc_d;
    logic                 chg_q, chg_d;
    logic [1:0]           ref_q, ref_d;
    logic                 ref_valid_q, ref_valid_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;
    logic                 dir_q, dir_d;
    logic                 pulse_q, pulse_d;
    logic [IDL_W-1:0]     idle_q, idle_d;
    logic                 moving_q, moving_d;
    logic                 err_skip_q, err_skip_d;
    logic                 err_ill_q, err_ill_d;

    logic                 stable;
    logic                 onehot;
    logic [1:0]           phase;
    logic [1:0]           delta;
    logic                 skip_set;
    logic                 ill_set;

    // Glitch filter: a candidate pattern must hold FILTER_CYCLES cycles to be accepted
    always_comb begin
        cand_d = sync2_q;
        cnt_d  = cnt_q;
        if (sync2_q != cand_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q < FILT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        stable = (cnt_q == FILT_MAX);
        acc_d  = stable ? cand_q : acc_q;
        chg_d  = stable && (cand_q != acc_q);
    end

    always_comb begin
        onehot = 1'b1;
        phase  = 2'd0;
        case (acc_q)
            4'b0001: phase = 2'd0;
            4'b0010: phase = 2'd1;
            4'b0100: phase = 2'd2;
            4'b1000: phase = 2'd3;
            default: onehot = 1'b0;
        endcase
        delta = phase - ref_q;
    end

    // Phase decode on each newly accepted pattern
    always_comb begin
        pos_d       = pos_q;
        dir_d       = dir_q;
        pulse_d     = 1'b0;
        ref_d       = ref_q;
        ref_valid_d = ref_valid_q;
        skip_set    = 1'b0;
        ill_set     = 1'b0;
        if (chg_q) begin
            if (onehot) begin
                ref_d = phase;
                if (!ref_valid_q) begin
                    ref_valid_d = 1'b1;
                end else begin
                    case (delta)
                        2'd1: begin
                            pos_d   = pos_q + POS_WIDTH'(1);
                            dir_d   = 1'b1;
                            pulse_d = 1'b1;
                        end
                        2'd3: begin
                            pos_d   = pos_q - POS_WIDTH'(1);
                            dir_d   = 1'b0;
                            pulse_d = 1'b1;
                        end
                        2'd2:    skip_set = 1'b1;
                        default: ;
                    endcase
                end
            end else if (acc_q != 4'b0000) begin
                ill_set     = 1'b1;
                ref_valid_d = 1'b0;
            end
        end
        if (zero_pos) begin
            pos_d = '0;
        end
        err_skip_d = skip_set | (err_skip_q & ~clr_err);
        err_ill_d  = ill_set  | (err_ill_q  & ~clr_err);
    end

    always_comb begin
        idle_d = idle_q;
        if (pulse_d) begin
            idle_d = IDLE_LOAD;
        end else if (idle_q != '0) begin
            idle_d = idle_q - IDL_W'(1);
        end
        moving_d = (idle_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            chg_q       <= 1'b0;
            ref_q       <= '0;
            ref_valid_q <= 1'b0;
            pos_q       <= '0;
            dir_q       <= 1'b0;
            pulse_q     <= 1'b0;
            idle_q      <= '0;
            moving_q    <= 1'b0;
            err_skip_q  <= 1'b0;
            err_ill_q   <= 1'b0;
        end else begin
            sync1_q     <= signal_in;
            sync2_q     <= sync1_q;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            chg_q       <= chg_d;
            ref_q       <= ref_d;
            ref_valid_q <= ref_valid_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            pulse_q     <= pulse_d;
            idle_q      <= idle_d;
            moving_q    <= moving_d;
            err_skip_q  <= err_skip_d;
            err_ill_q   <= err_ill_d;
        end
    end

    assign position    = pos_q;
    assign dir_out     = dir_q;
    assign step_pulse  = pulse_q;
    assign moving      = moving_q;
    assign ref_valid   = ref_valid_q;
    assign err_skip    = err_skip_q;
    assign err_illegal = err_ill_q;

endmodule
